// File: rtl/id_ex_pipeline_register_if.sv
// Decode-to-Execute bundle: D-side inputs from the decoder and hazard unit,
// E-side registered copies consumed by the Execute stage.
interface id_ex_pipeline_register_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              StallE;
    logic              FlushE;
    logic              ValidD;

    logic              RegWriteD;
    logic              ALUSrcD;
    logic              MemReadD;
    logic              MemWriteD;
    logic              JumpD;
    logic              BranchD;
    logic [1:0]        ResultSrcD;
    logic [2:0]        ALUOpD;
    logic [2:0]        funct3D;
    logic              funct7b5D;
    logic [DATA_W-1:0] RD1D;
    logic [DATA_W-1:0] RD2D;
    logic [DATA_W-1:0] PCD;
    logic [DATA_W-1:0] PCPlus4D;
    logic [DATA_W-1:0] ImmExtD;
    logic [4:0]        Rs1D;
    logic [4:0]        Rs2D;
    logic [4:0]        RdD;

    logic              RegWriteE;
    logic              ALUSrcE;
    logic              MemReadE;
    logic              MemWriteE;
    logic              JumpE;
    logic              BranchE;
    logic [1:0]        ResultSrcE;
    logic [2:0]        ALUOpE;
    logic [2:0]        funct3E;
    logic              funct7b5E;
    logic [DATA_W-1:0] RD1E;
    logic [DATA_W-1:0] RD2E;
    logic [DATA_W-1:0] PCE;
    logic [DATA_W-1:0] PCPlus4E;
    logic [DATA_W-1:0] ImmExtE;
    logic [4:0]        Rs1E;
    logic [4:0]        Rs2E;
    logic [4:0]        RdE;
    logic              ValidE;
    logic [CNT_W-1:0]  BubbleCnt;

    modport master (
        output StallE, FlushE, ValidD,
        output RegWriteD, ALUSrcD, MemReadD, MemWriteD, JumpD, BranchD,
        output ResultSrcD, ALUOpD, funct3D, funct7b5D,
        output RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        input  RegWriteE, ALUSrcE, MemReadE, MemWriteE, JumpE, BranchE,
        input  ResultSrcE, ALUOpE, funct3E, funct7b5E,
        input  RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
        input  ValidE, BubbleCnt
    );

    modport slave (
        input  StallE, FlushE, ValidD,
        input  RegWriteD, ALUSrcD, MemReadD, MemWriteD, JumpD, BranchD,
        input  ResultSrcD, ALUOpD, funct3D, funct7b5D,
        input  RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        output RegWriteE, ALUSrcE, MemReadE, MemWriteE, JumpE, BranchE,
        output ResultSrcE, ALUOpE, funct3E, funct7b5E,
        output RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
        output ValidE, BubbleCnt
    );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with flush-over-stall priority, valid-gated control
// side-effects and a saturating bubble counter for performance debug.
module id_ex_pipeline_register #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic                     clk,
    input logic                     rst,
    id_ex_pipeline_register_if.slave bus
);

    typedef struct packed {
        logic              reg_write;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic [1:0]        result_src;
        logic [2:0]        alu_op;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] imm_ext;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              valid;
    } stage_t;

    stage_t           stage_d;
    stage_t           stage_q;
    logic [CNT_W-1:0] bubble_cnt;
    logic             is_bubble;

    // A killed slot still carries its operands and indices; only the
    // side-effecting enables are forced low.
    always_comb begin
        stage_d            = '0;
        stage_d.reg_write  = bus.RegWriteD & bus.ValidD;
        stage_d.alu_src    = bus.ALUSrcD;
        stage_d.mem_read   = bus.MemReadD  & bus.ValidD;
        stage_d.mem_write  = bus.MemWriteD & bus.ValidD;
        stage_d.jump       = bus.JumpD     & bus.ValidD;
        stage_d.branch     = bus.BranchD   & bus.ValidD;
        stage_d.result_src = bus.ResultSrcD;
        stage_d.alu_op     = bus.ALUOpD;
        stage_d.funct3     = bus.funct3D;
        stage_d.funct7b5   = bus.funct7b5D;
        stage_d.rd1        = bus.RD1D;
        stage_d.rd2        = bus.RD2D;
        stage_d.pc         = bus.PCD;
        stage_d.pc_plus4   = bus.PCPlus4D;
        stage_d.imm_ext    = bus.ImmExtD;
        stage_d.rs1        = bus.Rs1D;
        stage_d.rs2        = bus.Rs2D;
        stage_d.rd         = bus.RdD;
        stage_d.valid      = bus.ValidD;
    end

    assign is_bubble = bus.FlushE | (~bus.StallE & ~bus.ValidD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q    <= '0;
            bubble_cnt <= '0;
        end else begin
            if (bus.FlushE) begin
                stage_q <= '0;
            end else if (!bus.StallE) begin
                stage_q <= stage_d;
            end
            // Saturate rather than wrap so a long run never reads as "few bubbles".
            if (is_bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.RegWriteE  = stage_q.reg_write;
    assign bus.ALUSrcE    = stage_q.alu_src;
    assign bus.MemReadE   = stage_q.mem_read;
    assign bus.MemWriteE  = stage_q.mem_write;
    assign bus.JumpE      = stage_q.jump;
    assign bus.BranchE    = stage_q.branch;
    assign bus.ResultSrcE = stage_q.result_src;
    assign bus.ALUOpE     = stage_q.alu_op;
    assign bus.funct3E    = stage_q.funct3;
    assign bus.funct7b5E  = stage_q.funct7b5;
    assign bus.RD1E       = stage_q.rd1;
    assign bus.RD2E       = stage_q.rd2;
    assign bus.PCE        = stage_q.pc;
    assign bus.PCPlus4E   = stage_q.pc_plus4;
    assign bus.ImmExtE    = stage_q.imm_ext;
    assign bus.Rs1E       = stage_q.rs1;
    assign bus.Rs2E       = stage_q.rs2;
    assign bus.RdE        = stage_q.rd;
    assign bus.ValidE     = stage_q.valid;
    assign bus.BubbleCnt  = bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Scoreboard bench for id_ex_pipeline_register: directed vectors push expected
// E-stage state per edge; a negedge monitor pops and compares.
module tb_id_ex_pipeline_register;

    typedef struct packed {
        logic        regWrite;
        logic        aluSrc;
        logic        memRead;
        logic        memWrite;
        logic        jump;
        logic        branch;
        logic [1:0]  resultSrc;
        logic [2:0]  aluOp;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic [31:0] immExt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        valid;
    } eState_t;

    typedef struct {
        eState_t     bundle;
        logic [15:0] cnt;
    } expItem_t;

    logic clk;
    logic rst;

    id_ex_pipeline_register_if #(.DATA_W(32), .CNT_W(16)) bus  ();
    id_ex_pipeline_register_if #(.DATA_W(32), .CNT_W(4))  bus4 ();

    id_ex_pipeline_register #(.DATA_W(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    id_ex_pipeline_register #(.DATA_W(32), .CNT_W(4)) dutSat (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    expItem_t    expQ[$];
    logic [15:0] satQ[$];
    eState_t     model;
    int          checks = 0;
    int          errors = 0;
    int          vecId  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic eState_t sampleE();
        eState_t s;
        s.regWrite  = bus.RegWriteE;
        s.aluSrc    = bus.ALUSrcE;
        s.memRead   = bus.MemReadE;
        s.memWrite  = bus.MemWriteE;
        s.jump      = bus.JumpE;
        s.branch    = bus.BranchE;
        s.resultSrc = bus.ResultSrcE;
        s.aluOp     = bus.ALUOpE;
        s.funct3    = bus.funct3E;
        s.funct7b5  = bus.funct7b5E;
        s.rd1       = bus.RD1E;
        s.rd2       = bus.RD2E;
        s.pc        = bus.PCE;
        s.pcPlus4   = bus.PCPlus4E;
        s.immExt    = bus.ImmExtE;
        s.rs1       = bus.Rs1E;
        s.rs2       = bus.Rs2E;
        s.rd        = bus.RdE;
        s.valid     = bus.ValidE;
        return s;
    endfunction

    // Reference behaviour: flush clears, stall holds, otherwise copy with
    // side-effecting controls gated by ValidD.
    function automatic eState_t modelNext(eState_t cur);
        eState_t n = cur;
        if (bus.FlushE) begin
            n = '0;
        end else if (!bus.StallE) begin
            n.regWrite  = bus.RegWriteD & bus.ValidD;
            n.aluSrc    = bus.ALUSrcD;
            n.memRead   = bus.MemReadD & bus.ValidD;
            n.memWrite  = bus.MemWriteD & bus.ValidD;
            n.jump      = bus.JumpD & bus.ValidD;
            n.branch    = bus.BranchD & bus.ValidD;
            n.resultSrc = bus.ResultSrcD;
            n.aluOp     = bus.ALUOpD;
            n.funct3    = bus.funct3D;
            n.funct7b5  = bus.funct7b5D;
            n.rd1       = bus.RD1D;
            n.rd2       = bus.RD2D;
            n.pc        = bus.PCD;
            n.pcPlus4   = bus.PCPlus4D;
            n.immExt    = bus.ImmExtD;
            n.rs1       = bus.Rs1D;
            n.rs2       = bus.Rs2D;
            n.rd        = bus.RdD;
            n.valid     = bus.ValidD;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input eState_t act, input eState_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic setD(input logic valid, input logic regWrite, input logic memWrite,
                        input logic jump, input logic branch, input logic [1:0] resultSrc,
                        input logic [2:0] aluOp, input logic [4:0] rd, input logic [4:0] rs2,
                        input logic [31:0] rd1, input logic [31:0] rd2);
        logic [7:0] v;
        vecId++;
        v = 8'(vecId);
        bus.ValidD     = valid;
        bus.RegWriteD  = regWrite;
        bus.MemWriteD  = memWrite;
        bus.JumpD      = jump;
        bus.BranchD    = branch;
        bus.ResultSrcD = resultSrc;
        bus.ALUOpD     = aluOp;
        bus.RdD        = rd;
        bus.Rs2D       = rs2;
        bus.RD1D       = rd1;
        bus.RD2D       = rd2;
        bus.ALUSrcD    = v[1];
        bus.MemReadD   = v[2];
        bus.funct3D    = v[2:0];
        bus.funct7b5D  = v[0];
        bus.Rs1D       = v[4:0] + 5'd3;
        bus.PCD        = 32'h0000_1000 + {22'd0, v, 2'b00};
        bus.PCPlus4D   = 32'h0000_1004 + {22'd0, v, 2'b00};
        bus.ImmExtD    = 32'hFFFF_F000 | {24'd0, v};
    endtask

    // One capturing edge; expCnt is the hand-computed bubble count after it.
    task automatic applyStimulus(input int expCnt);
        eState_t nxt;
        expItem_t item;
        nxt = modelNext(model);
        @(posedge clk);
        model       = nxt;
        item.bundle = nxt;
        item.cnt    = 16'(expCnt);
        expQ.push_back(item);
        #1;
    endtask

    task automatic drainQueue();
        for (int i = 0; i < 4 && (expQ.size() != 0 || satQ.size() != 0); i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (expQ.size() != 0 || satQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size() + satQ.size());
        end
    endtask

    // Pulses rst between edges and checks the asynchronous clear.
    task automatic asyncReset(input string name);
        drainQueue();
        #1 rst = 1'b1;
        #1;
        model = '0;
        checkOutput({name, "Bundle"}, sampleE(), '0);
        checkCount({name, "Cnt"}, bus.BubbleCnt, 16'd0);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        expItem_t item;
        logic [15:0] satExp;
        if (expQ.size() != 0) begin
            item = expQ.pop_front();
            checkOutput("bundle", sampleE(), item.bundle);
            checkCount("bubbleCnt", bus.BubbleCnt, item.cnt);
        end
        if (satQ.size() != 0) begin
            satExp = satQ.pop_front();
            checkCount("satCnt", {12'd0, bus4.BubbleCnt}, satExp);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        model = '0;
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;
        setD(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 5'd0, 32'd0, 32'd0);
        bus4.StallE     = 1'b1;
        bus4.FlushE     = 1'b0;
        bus4.ValidD     = 1'b1;
        bus4.RegWriteD  = 1'b0;
        bus4.ALUSrcD    = 1'b0;
        bus4.MemReadD   = 1'b0;
        bus4.MemWriteD  = 1'b0;
        bus4.JumpD      = 1'b0;
        bus4.BranchD    = 1'b0;
        bus4.ResultSrcD = 2'b00;
        bus4.ALUOpD     = 3'b000;
        bus4.funct3D    = 3'b000;
        bus4.funct7b5D  = 1'b0;
        bus4.RD1D       = 32'd0;
        bus4.RD2D       = 32'd0;
        bus4.PCD        = 32'd0;
        bus4.PCPlus4D   = 32'd0;
        bus4.ImmExtD    = 32'd0;
        bus4.Rs1D       = 5'd0;
        bus4.Rs2D       = 5'd0;
        bus4.RdD        = 5'd0;

        #12;
        checkOutput("resetBundle", sampleE(), '0);
        checkCount("resetCnt", bus.BubbleCnt, 16'd0);
        rst = 1'b0;

        // Load a bundle, clear it asynchronously, then reload it
        setD(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd4, 5'd0, 32'hDEADBEEF, 32'd0);
        applyStimulus(0);
        asyncReset("asyncReset");
        applyStimulus(0);

        // R-type
        setD(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd5, 5'd4, 32'd3, 32'd4);
        applyStimulus(0);

        // Stall holds RdE=7 while Decode moves on to RdD=9
        setD(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 5'd7, 5'd6, 32'd70, 32'd71);
        applyStimulus(0);
        setD(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'b011, 5'd9, 5'd8, 32'd90, 32'd91);
        bus.StallE = 1'b1;
        applyStimulus(0);
        applyStimulus(0);
        applyStimulus(0);
        bus.StallE = 1'b0;
        applyStimulus(0);

        // Store with stall and flush together: flush wins and counts
        setD(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 5'd2, 32'd100, 32'd200);
        bus.StallE = 1'b1;
        bus.FlushE = 1'b1;
        applyStimulus(1);
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;

        // Killed slot keeps operands and ResultSrc but drops enables
        setD(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 3'b001, 5'd1, 5'd3, 32'h1234_5678, 32'd5);
        applyStimulus(2);

        setD(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 3'b111, 5'd31, 5'd30, 32'hFFFF_FFFF, 32'hA5A5_A5A5);
        applyStimulus(2);
        bus.FlushE = 1'b1;
        applyStimulus(3);
        bus.FlushE = 1'b0;

        // Stall with an invalid Decode slot is not a bubble
        setD(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'b100, 5'd12, 5'd13, 32'd14, 32'd15);
        bus.StallE = 1'b1;
        applyStimulus(3);
        applyStimulus(3);
        bus.StallE = 1'b0;
        setD(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'b101, 5'd1, 5'd0, 32'h0000_0040, 32'd0);
        applyStimulus(3);

        // Reset mid-stall: reset state then stall keeps it
        bus.StallE = 1'b1;
        asyncReset("stallReset");
        applyStimulus(0);
        bus.StallE = 1'b0;
        applyStimulus(0);

        // Saturation on the 4-bit counter instance
        bus4.StallE = 1'b0;
        bus4.FlushE = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            satQ.push_back(16'((k > 15) ? 15 : k));
            #1;
        end
        bus4.FlushE = 1'b0;
        bus4.StallE = 1'b1;

        drainQueue();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
